// File: rtl/pc_branch_unit.sv
// PC register and branch resolver: decision and pc_plus4 are combinational, and the new pc shows one cycle after the edge.
// stall freezes pc, retired and state. HALT holds until resume. A misaligned target traps until reset.
module pc_branch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [2:0]       branch_type,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero,
  input  logic             lt,
  input  logic             gt,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             taken,
  output logic             trap,
  output logic [WIDTH-1:0] trap_addr,
  output logic             halted,
  output logic [WIDTH-1:0] retired
);

  typedef enum logic [1:0] {RUN, HALT, TRAP} state_t;

  state_t           state;
  logic             cond;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic             misaligned;

  // lt/gt can be stale on equal operands, so zero qualifies both orderings
  always_comb begin
    cond = 1'b0;
    case (branch_type)
      3'b000:         cond = zero;
      3'b001:         cond = !zero;
      3'b100:         cond = lt & !zero;
      3'b101:         cond = gt | zero;
      3'b010, 3'b011: cond = 1'b1;
      default:        cond = 1'b0;
    endcase
  end

  assign pc_plus4   = pc + WIDTH'(4);
  assign target     = (branch_type == 3'b011) ? (alu_result & ~WIDTH'(1)) : (pc + imm);
  assign taken      = (state == RUN) & branch_en & cond;
  assign next_pc    = taken ? target : pc_plus4;
  assign misaligned = taken & (target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_VECTOR;
      trap      <= 1'b0;
      trap_addr <= '0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (misaligned) begin
              state     <= TRAP;
              trap      <= 1'b1;
              trap_addr <= target;
            end else begin
              pc      <= next_pc;
              retired <= retired + WIDTH'(1);
              if (halt_req) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
          end
        end
        HALT: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        TRAP:    state <= TRAP;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scenario bench for pc_branch_unit: each instruction pushes its expected post-edge state and is scored after the edge.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_en, zero, lt, gt, halt_req, resume;
  logic [2:0]  branch_type;
  logic [31:0] imm, alu_result;
  logic [31:0] pc, pc_plus4, trap_addr, retired;
  logic        taken, trap, halted;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        trap;
    logic [31:0] taddr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pc_branch_unit #(.WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_en(branch_en),
    .branch_type(branch_type), .imm(imm), .alu_result(alu_result),
    .zero(zero), .lt(lt), .gt(gt), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .trap(trap),
    .trap_addr(trap_addr), .halted(halted), .retired(retired)
  );

  // One instruction: drive at negedge, score taken before the edge and state after it
  task automatic step(input string nm, input logic etk, input logic [31:0] epc, input logic [31:0] eret,
                      input logic eh, input logic etr, input logic [31:0] eta,
                      input logic st = 1'b0, input logic ben = 1'b0, input logic [2:0] bt = 3'b000,
                      input logic [31:0] im = 32'h0, input logic [31:0] al = 32'h0,
                      input logic z = 1'b0, input logic l = 1'b0, input logic g = 1'b0,
                      input logic hr = 1'b0, input logic rs = 1'b0);
    exp_t e;
    exp_t got;
    e.pc = epc; e.retired = eret; e.halted = eh; e.trap = etr; e.taddr = eta;
    @(negedge clk);
    stall = st; branch_en = ben; branch_type = bt; imm = im; alu_result = al;
    zero = z; lt = l; gt = g; halt_req = hr; resume = rs;
    sb.push_back(e);
    #1;
    n_assert++;
    if (taken !== etk) begin
      n_fail++; $display("FAIL %s taken: got %b want %b", nm, taken, etk);
    end
    @(posedge clk);
    #1;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard empty", nm);
    end else begin
      got = sb.pop_front();
      n_assert += 5;
      if (pc !== got.pc) begin
        n_fail++; $display("FAIL %s pc: got %h want %h", nm, pc, got.pc);
      end
      if (pc_plus4 !== got.pc + 32'd4) begin
        n_fail++; $display("FAIL %s pc_plus4: got %h want %h", nm, pc_plus4, got.pc + 32'd4);
      end
      if (retired !== got.retired) begin
        n_fail++; $display("FAIL %s retired: got %0d want %0d", nm, retired, got.retired);
      end
      if (halted !== got.halted || trap !== got.trap) begin
        n_fail++; $display("FAIL %s halted/trap: got %b/%b want %b/%b", nm, halted, trap, got.halted, got.trap);
      end
      if (trap_addr !== got.taddr) begin
        n_fail++; $display("FAIL %s trap_addr: got %h want %h", nm, trap_addr, got.taddr);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    stall = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; branch_en = 1'b0; branch_type = 3'b000; imm = '0;
    alu_result = '0; zero = 1'b0; lt = 1'b0; gt = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #3;
    n_assert++;
    if (pc !== 32'h0 || retired !== 32'h0 || trap !== 1'b0 || trap_addr !== 32'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h ret=%0d trap=%b taddr=%h halted=%b want all zero", pc, retired, trap, trap_addr, halted);
    end
    n_assert++;
    if (pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL reset_pc_plus4: got %h want 00000004", pc_plus4);
    end
    release_reset();
  endtask

  task automatic test_sequential();
    step("seq0", 1'b0, 32'h4,  32'd1, 1'b0, 1'b0, 32'h0);
    step("seq1", 1'b0, 32'h8,  32'd2, 1'b0, 1'b0, 32'h0);
    step("seq2", 1'b0, 32'hC,  32'd3, 1'b0, 1'b0, 32'h0);
    step("seq3", 1'b0, 32'h10, 32'd4, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    step("jal_to_20", 1'b1, 32'h20, 32'd5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h10);
    step("beq_taken", 1'b1, 32'h18, 32'd6, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFF8, 32'h0, 1'b1);
    step("jal_back",  1'b1, 32'h20, 32'd7, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h8);
    step("beq_not",   1'b0, 32'h24, 32'd8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFF8, 32'h0, 1'b0);
  endtask

  task automatic test_flags();
    step("blt_stale",  1'b0, 32'h28, 32'd9,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0);
    step("bge_eq",     1'b1, 32'h38, 32'd10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b101, 32'h10,  32'h0, 1'b1, 1'b0, 1'b0);
    step("bne_taken",  1'b1, 32'h40, 32'd11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b001, 32'h8,   32'h0, 1'b0);
    step("blt_taken",  1'b1, 32'h0,  32'd12, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b100, 32'hFFFF_FFC0, 32'h0, 1'b0, 1'b1);
    step("undef_code", 1'b0, 32'h4,  32'd13, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b110, 32'h40,  32'h0, 1'b1, 1'b1, 1'b1);
    step("jal_no_en",  1'b0, 32'h8,  32'd14, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b010, 32'h40);
  endtask

  task automatic test_wrap();
    step("imm_wrap",   1'b1, 32'h0,         32'd15, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'hFFFF_FFF8);
    step("jalr_top",   1'b1, 32'hFFFF_FFFC, 32'd16, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b011, 32'h0, 32'hFFFF_FFFD);
    step("pc4_wrap",   1'b0, 32'h0,         32'd17, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_halt();
    step("jal_to_10",  1'b1, 32'h10, 32'd18, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h10);
    step("halt_jal",   1'b1, 32'h50, 32'd19, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("halt_hold0", 1'b0, 32'h50, 32'd19, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3'b010, 32'h100);
    step("halt_hold1", 1'b0, 32'h50, 32'd19, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("halt_hold2", 1'b0, 32'h50, 32'd19, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("resume",     1'b0, 32'h50, 32'd19, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("after_res",  1'b0, 32'h54, 32'd20, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_stall();
    step("stall_br",   1'b1, 32'h54, 32'd20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h20);
    step("stall_halt", 1'b0, 32'h54, 32'd20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("unstall",    1'b0, 32'h58, 32'd21, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_trap();
    // Misaligned JALR together with halt_req: trap wins, halted stays low
    step("jalr_trap",  1'b1, 32'h58, 32'd21, 1'b0, 1'b1, 32'h102, 1'b0, 1'b1, 3'b011, 32'h0, 32'h103, 1'b0, 1'b0, 1'b0, 1'b1);
    step("trap_res",   1'b0, 32'h58, 32'd21, 1'b0, 1'b1, 32'h102, 1'b0, 1'b1, 3'b010, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("trap_hreq",  1'b0, 32'h58, 32'd21, 1'b0, 1'b1, 32'h102, 1'b0, 1'b1, 3'b011, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b1;
    #1;
    n_assert++;
    if (pc !== 32'h0 || trap !== 1'b0 || trap_addr !== 32'h0 || retired !== 32'h0) begin
      n_fail++; $display("FAIL trap_reset: pc=%h trap=%b taddr=%h ret=%0d want 0/0/0/0", pc, trap, trap_addr, retired);
    end
    release_reset();
    step("imm_trap",   1'b1, 32'h0, 32'd0, 1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 3'b000, 32'h6, 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    release_reset();
    step("ar_seq0",  1'b0, 32'h4, 32'd1, 1'b0, 1'b0, 32'h0);
    step("ar_seq1",  1'b0, 32'h8, 32'd2, 1'b0, 1'b0, 32'h0);
    step("ar_trap",  1'b1, 32'h8, 32'd2, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 3'b001, 32'h2, 32'h0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0; stall = 1'b1;
    #1;
    n_assert++;
    if (pc !== 32'h0 || trap !== 1'b0 || trap_addr !== 32'h0 || retired !== 32'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h trap=%b taddr=%h ret=%0d halted=%b want all zero", pc, trap, trap_addr, retired, halted);
    end
    release_reset();
    step("post_reset", 1'b0, 32'h4, 32'd1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_flags();
    test_wrap();
    test_halt();
    test_stall();
    test_trap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
